// File: rtl/core_pkg.sv
// Shared definitions for the instruction sequencer: inst word bit positions,
// the idle instruction and the sequencer state encoding.
package core_pkg;

    localparam int INST_W  = 35;
    localparam int INST_AW = 11;

    localparam int B_MODE     = 34;
    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP       = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX       = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs deselected and write-disabled, every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRST,
        S_W_L0,
        S_LOAD,
        S_X_L0,
        S_EXEC,
        S_DRAIN,
        S_ACC,
        S_DONE
    } state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Host/core-facing signal bundle of the instruction sequencer.
interface core_inst_seq_if;
    import core_pkg::*;

    logic              start;
    logic              mode;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [3:0]        kij_idx;
    logic [7:0]        onij_idx;

    modport master (
        input  start, mode, ofifo_valid,
        output inst, core_rst, busy, done, out_valid, kij_idx, onij_idx
    );

    modport slave (
        output start, mode, ofifo_valid,
        input  inst, core_rst, busy, done, out_valid, kij_idx, onij_idx
    );

endinterface

// File: rtl/core_inst_seq_acc_addr_gen.sv
// Accumulation-pass psum read address: walks kernel offsets (ki,kj) inside each
// output pixel (orow,ocol) with wrap counters, so no divider is needed.
module acc_addr_gen
    import core_pkg::*;
#(
    parameter int K     = 3,
    parameter int IN_W  = 6,
    parameter int OUT_W = 4,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step_j,
    input  logic          step_pix,
    output logic [AW-1:0] addr
);

    localparam int LEN_NIJ = IN_W * IN_W;
    localparam int KW      = $clog2(K + 1);
    localparam int OW      = $clog2(OUT_W + 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_W - 1);

    logic [KW-1:0] ki, kj;
    logic [OW-1:0] orow, ocol;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ki   <= '0;
            kj   <= '0;
            orow <= '0;
            ocol <= '0;
        end else if (clear) begin
            ki   <= '0;
            kj   <= '0;
            orow <= '0;
            ocol <= '0;
        end else begin
            if (step_j) begin
                if (kj == K_LAST) begin
                    kj <= '0;
                    ki <= (ki == K_LAST) ? '0 : ki + 1'b1;
                end else begin
                    kj <= kj + 1'b1;
                end
            end
            if (step_pix) begin
                if (ocol == O_LAST) begin
                    ocol <= '0;
                    orow <= (orow == O_LAST) ? '0 : orow + 1'b1;
                end else begin
                    ocol <= ocol + 1'b1;
                end
            end
        end
    end

    // Kernel position selects the kij psum plane; pixel plus offset selects the nij word.
    assign addr = AW'((int'(ki) * K + int'(kj)) * LEN_NIJ
                      + (int'(orow) + int'(ki)) * IN_W + int'(ocol) + int'(kj));

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer: one start pulse issues every kij pass (load, execute,
// drain to pmem) followed by the per-pixel accumulation pass.
module core_inst_seq
    import core_pkg::*;
#(
    parameter int            ROW     = 8,
    parameter int            COL     = 8,
    parameter int            K       = 3,
    parameter int            IN_W    = 6,
    parameter int            OUT_W   = 4,
    parameter int            AW      = 11,
    parameter logic [AW-1:0] W_BASE  = 11'h400,
    parameter int            RST_CYC = 10
) (
    input logic            clk,
    input logic            reset,
    core_inst_seq_if.master bus
);

    localparam int LEN_KIJ  = K * K;
    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_ONIJ = OUT_W * OUT_W;
    localparam int EXEC_LEN = LEN_NIJ + ROW + COL;
    localparam int CNT_W    = $clog2(EXEC_LEN + RST_CYC + LEN_KIJ + 8);

    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_RST  = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] C_COL  = CNT_W'(COL);
    localparam logic [CNT_W-1:0] C_COL1 = CNT_W'(COL + 1);
    localparam logic [CNT_W-1:0] C_NIJ  = CNT_W'(LEN_NIJ);
    localparam logic [CNT_W-1:0] C_NIJM = CNT_W'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] C_EXE  = CNT_W'(EXEC_LEN);
    localparam logic [CNT_W-1:0] C_EXE1 = CNT_W'(EXEC_LEN + 1);
    localparam logic [CNT_W-1:0] C_KIJ  = CNT_W'(LEN_KIJ);
    localparam logic [CNT_W-1:0] C_KIJ1 = CNT_W'(LEN_KIJ + 1);
    localparam logic [CNT_W-1:0] C_KIJ3 = CNT_W'(LEN_KIJ + 3);
    localparam logic [3:0]       KIJ_LAST  = 4'(LEN_KIJ - 1);
    localparam logic [7:0]       ONIJ_LAST = 8'(LEN_ONIJ - 1);

    if (LEN_KIJ * LEN_NIJ > (1 << AW)) begin : g_bad_aw
        $error("psum planes K*K*IN_W*IN_W do not fit the AW-bit address space");
    end
    if (AW != INST_AW || OUT_W != IN_W - K + 1 || LEN_KIJ > 16 || LEN_ONIJ > 256) begin : g_bad_geom
        $error("inconsistent sequencer geometry");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        kij_q, kij_d;
    logic [7:0]        onij_q, onij_d;
    logic              mode_q, mode_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              core_rst_q, core_rst_d, busy_q, busy_d;
    logic              done_q, done_d, out_valid_q, out_valid_d;
    logic              acc_clear, acc_step_j, acc_step_pix;
    logic [AW-1:0]     acc_addr;

    acc_addr_gen #(.K(K), .IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) u_acc_addr (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .step_j   (acc_step_j),
        .step_pix (acc_step_pix),
        .addr     (acc_addr)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        kij_d        = kij_q;
        onij_d       = onij_q;
        mode_d       = mode_q;
        inst_d       = INST_IDLE;
        inst_d[B_MODE] = mode_q;
        core_rst_d   = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        out_valid_d  = 1'b0;
        acc_clear    = 1'b0;
        acc_step_j   = 1'b0;
        acc_step_pix = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d         = 1'b0;
                cnt_d          = '0;
                inst_d[B_MODE] = 1'b0;
                if (bus.start) begin
                    state_d        = S_CRST;
                    mode_d         = bus.mode;
                    kij_d          = '0;
                    onij_d         = '0;
                    busy_d         = 1'b1;
                    inst_d[B_MODE] = bus.mode;
                    acc_clear      = 1'b1;
                end
            end
            S_CRST: begin
                core_rst_d = (cnt_q < C_RST);
                if (cnt_q == C_RST) begin
                    state_d = S_W_L0;
                    cnt_d   = '0;
                end
            end
            S_W_L0: begin
                if (cnt_q < C_COL) begin
                    inst_d[B_CEN_X]     = 1'b0;
                    inst_d[B_AX +: AW]  = AW'(int'(W_BASE) + int'(kij_q) * COL + int'(cnt_q));
                    inst_d[B_IFIFO_WR]  = mode_q;
                    inst_d[B_L0_WR]     = !mode_q;
                end
                if (cnt_q == C_COL) begin
                    state_d = mode_q ? S_X_L0 : S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                inst_d[B_L0_RD] = (cnt_q <= C_COL);
                inst_d[B_LOAD]  = (cnt_q != '0) && (cnt_q <= C_COL);
                if (cnt_q == C_COL1) begin
                    state_d = S_X_L0;
                    cnt_d   = '0;
                end
            end
            S_X_L0: begin
                if (cnt_q < C_NIJ) begin
                    inst_d[B_CEN_X]    = 1'b0;
                    inst_d[B_AX +: AW] = AW'(cnt_q);
                    inst_d[B_L0_WR]    = 1'b1;
                end
                if (cnt_q == C_NIJ) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end
            end
            S_EXEC: begin
                // The first cycle only primes the L0 read; execution follows one cycle later.
                inst_d[B_L0_RD]    = (cnt_q <= C_EXE);
                inst_d[B_EXEC]     = (cnt_q != '0) && (cnt_q <= C_EXE);
                inst_d[B_IFIFO_RD] = mode_q && (cnt_q != '0) && (cnt_q <= C_EXE);
                if (cnt_q == C_EXE1) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                inst_d[B_OFIFO_RD] = 1'b1;
                inst_d[B_AP +: AW] = AW'(int'(kij_q) * LEN_NIJ + int'(cnt_q));
                cnt_d              = cnt_q;
                if (bus.ofifo_valid) begin
                    inst_d[B_CEN_P] = 1'b0;
                    inst_d[B_WEN_P] = 1'b0;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == C_NIJM) begin
                        cnt_d = '0;
                        if (kij_q == KIJ_LAST) begin
                            state_d = S_ACC;
                        end else begin
                            kij_d   = kij_q + 1'b1;
                            state_d = S_CRST;
                        end
                    end
                end
            end
            S_ACC: begin
                core_rst_d = (cnt_q == '0);
                if ((cnt_q != '0) && (cnt_q <= C_KIJ)) begin
                    inst_d[B_CEN_P]    = 1'b0;
                    inst_d[B_AP +: AW] = acc_addr;
                    acc_step_j         = 1'b1;
                end
                // SRAM read data lags the address by a cycle, so acc trails the reads.
                inst_d[B_ACC] = (cnt_q > C_ONE) && (cnt_q <= C_KIJ1);
                if (cnt_q == C_KIJ3) begin
                    out_valid_d  = 1'b1;
                    acc_step_pix = 1'b1;
                    cnt_d        = '0;
                    if (onij_q == ONIJ_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        onij_d = onij_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            kij_q       <= '0;
            onij_q      <= '0;
            mode_q      <= 1'b0;
            inst_q      <= INST_IDLE;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kij_q       <= kij_d;
            onij_q      <= onij_d;
            mode_q      <= mode_d;
            inst_q      <= inst_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.inst      = inst_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.kij_idx   = kij_q;
    assign bus.onij_idx  = onij_q;

endmodule
